shift_reg_sequencer: RTL and testbench

- Command-driven controller for the N-word x M-bit shift/rotate register. It sequences that register's OPMODE/CE/reset pins.
- Accepts queued commands from a requester through a valid/ready handshake. Each command is either reload-from-SRINIT or K shift/rotate steps.
- Optionally streams each word shifted out of DOUT to a downstream consumer, with backpressure.
- Sits between the register and its control/consumer logic.

---
 rtl/shift_reg_sequencer.sv | 109 ++++++++++
 tb/tb_shift_reg_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: queues reload/shift commands and drives a shift register's OPMODE/CE/reset, optionally streaming shifted-out words.
module shift_reg_sequencer #(
    parameter int N     = 4,
    parameter int M     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_emit,
    output logic [1:0]       sr_opmode,
    output logic             sr_ce,
    output logic             sr_load,
    input  logic [M-1:0]     sr_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_data,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    typedef struct packed {
        logic             load;
        logic [1:0]       op;
        logic [CNT_W-1:0] cnt;
        logic             emit;
    } cmd_t;

    // N only describes the controlled register; nothing here depends on it.
    if (N < 1) begin : g_n_unused
    end

    state_t           state, next;
    cmd_t             q [2];
    cmd_t             head;
    logic             wp, rp, rdy_en, emit_r, push, pop, step_ok;
    logic [1:0]       qn;
    logic [CNT_W-1:0] rem;

    assign head      = q[rp];
    assign cmd_ready = rdy_en && qn != 2'd2;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state == IDLE && qn != 2'd0;
    assign step_ok   = !emit_r || !out_valid || out_ready;
    assign sr_ce     = state == RUN && step_ok;
    assign busy      = state != IDLE || qn != 2'd0;

    always_ff @(posedge clk)
        if (push) q[wp] <= {cmd_load, cmd_op, cmd_cnt, cmd_emit};

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wp     <= 1'b0;
            rp     <= 1'b0;
            qn     <= 2'd0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) wp <= !wp;
            if (pop) rp <= !rp;
            qn <= qn + 2'(push) - 2'(pop);
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (pop) next = head.load ? LOAD : head.cnt == '0 ? DONE : RUN;
            LOAD:    next = DONE;
            RUN:     if (step_ok && rem == CNT_W'(1)) next = DONE;
            default: next = IDLE;
        endcase
    end

    // sr_load and done are registered so the register's reset pin never sees a decode glitch.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sr_opmode <= 2'b00;
            sr_load   <= 1'b0;
            done      <= 1'b0;
            rem       <= '0;
            emit_r    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            sr_load <= next == LOAD;
            done    <= next == DONE;
            if (pop) begin
                sr_opmode <= head.op;
                rem       <= head.cnt;
                emit_r    <= head.emit;
            end
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (sr_ce) begin
                rem <= rem - 1'b1;
                if (emit_r) begin
                    out_data  <= sr_dout;
                    out_valid <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb_shift_reg_sequencer: directed checks of the sequencer driving a behavioural 4x8 shift register.
module tb_shift_reg_sequencer;
    localparam int          N      = 4;
    localparam int          M      = 8;
    localparam int          CNT_W  = 8;
    localparam logic [31:0] SRINIT = 32'h44332211;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid, cmd_ready, cmd_load, cmd_emit;
    logic [1:0]       cmd_op, sr_opmode;
    logic [CNT_W-1:0] cmd_cnt;
    logic             sr_ce, sr_load, out_valid, out_ready, busy, done;
    logic [M-1:0]     sr_dout, out_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_reg_sequencer #(.N(N), .M(M), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_emit(cmd_emit),
        .sr_opmode(sr_opmode), .sr_ce(sr_ce), .sr_load(sr_load), .sr_dout(sr_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    // Behavioural register: controls are sampled mid-cycle and applied on the next rising edge.
    logic [31:0] sr_q;
    logic        ld_s, ce_s;
    logic [1:0]  op_s;
    assign sr_dout = sr_q[7:0];

    always @(negedge clk) begin
        ld_s <= sr_load;
        ce_s <= sr_ce;
        op_s <= sr_opmode;
    end

    always @(posedge clk or negedge rst)
        if (!rst) sr_q <= SRINIT;
        else if (ld_s) sr_q <= SRINIT;
        else if (ce_s)
            case (op_s)
                2'b00:   sr_q <= sr_q >> M;
                2'b01:   sr_q <= sr_q << M;
                2'b10:   sr_q <= {sr_q[7:0], sr_q[31:8]};
                default: sr_q <= {sr_q[23:0], sr_q[31:24]};
            endcase

    int         ce_n = 0, done_n = 0, load_n = 0, wn = 0;
    logic [7:0] wlog [64];

    always @(negedge clk)
        if (rst) begin
            if (sr_ce) ce_n <= ce_n + 1;
            if (done) done_n <= done_n + 1;
            if (sr_load) load_n <= load_n + 1;
            if (out_valid && out_ready && wn < 64) begin
                wlog[wn] <= out_data;
                wn <= wn + 1;
            end
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic ld, input logic [1:0] op, input logic [7:0] cnt, input logic em);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_emit  = em;
        chk("push_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    int         ce0, d0, l0, w0;
    logic [7:0] exp_w [4];

    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 2'b00; cmd_cnt = '0; cmd_emit = 1'b0;
        out_ready = 1'b1;
        exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'h33; exp_w[3] = 8'h44;
        repeat (3) tick();
        chk("rst_opmode", sr_opmode, 0);
        chk("rst_ce", sr_ce, 0);
        chk("rst_load", sr_load, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_dout", sr_dout, 8'h11);

        // rotate right x4 with emit
        ce0 = ce_n; d0 = done_n;
        push(1'b0, 2'b10, 8'd4, 1'b1);
        tick();
        chk("rr_ce_first", sr_ce, 1);
        chk("rr_opmode", sr_opmode, 2'b10);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_valid", out_valid, 1);
            chk("rr_data", out_data, exp_w[i]);
        end
        chk("rr_done_pulse", done, 1);
        tick();
        chk("rr_done_clear", done, 0);
        chk("rr_valid_clear", out_valid, 0);
        chk("rr_ce_count", 32'(ce_n - ce0), 4);
        chk("rr_done_count", 32'(done_n - d0), 1);
        chk("rr_reg", sr_q, SRINIT);

        // backpressure after first word
        w0 = wn;
        push(1'b0, 2'b10, 8'd4, 1'b1);
        tick();
        tick();
        chk("bp_first", out_data, 8'h11);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_data", out_data, 8'h11);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_stall_ce", sr_ce, 0);
        end
        out_ready = 1'b1;
        wait_idle();
        tick();
        tick();
        chk("bp_word_count", 32'(wn - w0), 4);
        for (int i = 0; i < 4; i++) chk("bp_word", wlog[w0 + i], exp_w[i]);
        chk("bp_reg", sr_q, SRINIT);

        // shift left, reload, zero-count queued behind
        ce0 = ce_n; d0 = done_n; l0 = load_n;
        push(1'b0, 2'b01, 8'd1, 1'b0);
        push(1'b1, 2'b00, 8'd0, 1'b0);
        push(1'b0, 2'b00, 8'd0, 1'b0);
        chk("sl_full_ready", cmd_ready, 0);
        chk("sl_reg", sr_q, 32'h33221100);
        tick();
        chk("sl_still_full", cmd_ready, 0);
        tick();
        chk("ld_pulse", sr_load, 1);
        chk("ld_ready_back", cmd_ready, 1);
        chk("ld_ce", sr_ce, 0);
        tick();
        chk("ld_pulse_end", sr_load, 0);
        chk("ld_reg", sr_q, SRINIT);
        wait_idle();
        chk("sl_done_count", 32'(done_n - d0), 3);
        chk("sl_load_count", 32'(load_n - l0), 1);
        chk("sl_ce_count", 32'(ce_n - ce0), 1);

        // zero count
        ce0 = ce_n; d0 = done_n;
        push(1'b0, 2'b11, 8'd0, 1'b1);
        tick();
        chk("zc_done", done, 1);
        chk("zc_ce", sr_ce, 0);
        tick();
        chk("zc_done_clear", done, 0);
        chk("zc_ce_count", 32'(ce_n - ce0), 0);
        chk("zc_done_count", 32'(done_n - d0), 1);
        chk("zc_reg", sr_q, SRINIT);

        // reset during step 2 with a second command queued
        d0 = done_n;
        push(1'b0, 2'b10, 8'd4, 1'b1);
        push(1'b0, 2'b01, 8'd2, 1'b0);
        tick();
        chk("mr_ce", sr_ce, 1);
        rst = 1'b0;
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        repeat (2) tick();
        rst = 1'b1;
        ce0 = ce_n;
        repeat (10) tick();
        chk("mr_idle_busy", busy, 0);
        chk("mr_idle_ready", cmd_ready, 1);
        chk("mr_idle_valid", out_valid, 0);
        chk("mr_no_ce", 32'(ce_n - ce0), 0);
        chk("mr_no_done", 32'(done_n - d0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
